// File: rtl/irq_timer_pkg.sv
// Shared types and default sizes for the multi-channel interrupt timer.
package irq_timer_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 10;

endpackage

// File: rtl/irq_timer_chan.sv
// One timer channel: countdown engine, run/idle FSM, sticky pending/overrun flags.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   CH_IDLE | counter stopped, cnt held at 0, waiting for a start write
//   CH_RUN  | counting down on each tick; expiry when cnt==1 on a tick
module irq_timer_chan
    import irq_timer_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tick,
    input  logic          i_wr,
    input  logic [CW-1:0] i_value,
    input  logic          i_periodic,
    input  logic          i_en,
    input  logic          i_ack,
    output logic          o_running,
    output logic          o_pending,
    output logic          o_overrun
);

    ch_state_e     r_state;
    ch_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_reload;
    logic          r_periodic;
    logic          r_pending;
    logic          r_overrun;
    logic          w_start;
    logic          w_stop;
    logic          w_expire;

    // Decode write intent and expiry; a start or stop in the same cycle overrides expiry.
    always_comb begin
        w_start     = i_wr && i_en && (i_value != '0);
        w_stop      = i_wr && !i_en;
        w_expire    = (r_state == CH_RUN) && i_tick && (r_cnt == CW'(1)) && !w_start && !w_stop;
        w_state_nxt = r_state;
        case (r_state)
            CH_IDLE: if (w_start) w_state_nxt = CH_RUN;
            CH_RUN: begin
                if (w_stop)                         w_state_nxt = CH_IDLE;
                else if (w_expire && !r_periodic)   w_state_nxt = CH_IDLE;
            end
            default: w_state_nxt = CH_IDLE;
        endcase
    end

    // State register, counter datapath and sticky flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= CH_IDLE;
            r_cnt      <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_stop) begin
                r_cnt <= '0;
            end else if (w_start) begin
                r_cnt      <= i_value;
                r_reload   <= i_value;
                r_periodic <= i_periodic;
            end else if (w_expire) begin
                r_cnt <= r_periodic ? r_reload : '0;
            end else if ((r_state == CH_RUN) && i_tick) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // A new expiry beats a same-cycle ack; overrun only if the old event is still unacked.
            if (w_stop) begin
                r_pending <= 1'b0;
                r_overrun <= 1'b0;
            end else if (w_expire) begin
                r_pending <= 1'b1;
                if (r_pending && !i_ack) r_overrun <= 1'b1;
            end else if (i_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_running = (r_state == CH_RUN);
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Multi-channel interrupt timer with a round-robin IRQ presenter.
// Optional build macro IRQ_TIMER_PRESCALE_EN adds a shared clock divider
// so channels count in units of PRESCALE clocks.
//
//   arb state | meaning
//   ----------+------------------------------------------------------
//   ARB_IDLE  | irq low; grants the next pending channel from rr_ptr
//   ARB_BUSY  | irq high with stable irq_id until ack or stop write
module irq_timer_ctrl
    import irq_timer_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
`ifdef IRQ_TIMER_PRESCALE_EN
    parameter int PRESCALE = 1024,
`endif
    localparam int IDW = $clog2(NCH)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_cfg_we,
    input  logic [IDW-1:0] i_cfg_ch,
    input  logic [CW-1:0]  i_cfg_value,
    input  logic           i_cfg_periodic,
    input  logic           i_cfg_en,
    output logic           o_irq,
    output logic [IDW-1:0] o_irq_id,
    input  logic           i_irq_ack,
    output logic [NCH-1:0] o_running,
    output logic [NCH-1:0] o_pending,
    output logic [NCH-1:0] o_overrun
);

    logic           w_tick;
    logic [NCH-1:0] w_wr_vec;
    logic [NCH-1:0] w_stop_vec;
    logic [NCH-1:0] w_ack_vec;
    logic           w_ack_apply;
    logic           w_stop_presented;
    logic [IDW:0]   w_pick;

    arb_state_e     r_arb_state;
    arb_state_e     w_arb_nxt;
    logic [IDW-1:0] r_irq_id;
    logic [IDW-1:0] w_irq_id_nxt;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] w_rr_nxt;

`ifdef IRQ_TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] r_div;

    // Free-running divider down-counter; tick fires on terminal count.
    always_ff @(posedge i_clk) begin
        if (i_rst)              r_div <= PW'(PRESCALE - 1);
        else if (r_div == '0)   r_div <= PW'(PRESCALE - 1);
        else                    r_div <= r_div - 1'b1;
    end

    assign w_tick = (r_div == '0);
`else
    assign w_tick = 1'b1;
`endif

    assign w_ack_apply      = (r_arb_state == ARB_BUSY) && i_irq_ack;
    assign w_stop_presented = (r_arb_state == ARB_BUSY) && i_cfg_we && !i_cfg_en
                              && (i_cfg_ch == r_irq_id);

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            assign w_wr_vec[g]   = i_cfg_we && (i_cfg_ch == IDW'(g));
            assign w_stop_vec[g] = w_wr_vec[g] && !i_cfg_en;
            assign w_ack_vec[g]  = w_ack_apply && (r_irq_id == IDW'(g));

            irq_timer_chan #(.CW(CW)) u_chan (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_tick     (w_tick),
                .i_wr       (w_wr_vec[g]),
                .i_value    (i_cfg_value),
                .i_periodic (i_cfg_periodic),
                .i_en       (i_cfg_en),
                .i_ack      (w_ack_vec[g]),
                .o_running  (o_running[g]),
                .o_pending  (o_pending[g]),
                .o_overrun  (o_overrun[g])
            );
        end
    endgenerate

    // Returns {found, id}: first requester at or above ptr, wrapping at NCH.
    function automatic logic [IDW:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [IDW-1:0] ptr);
        logic           found;
        logic [IDW-1:0] id;
        int             idx;
        found = 1'b0;
        id    = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                id    = IDW'(idx);
            end
        end
        return {found, id};
    endfunction

    // Channels being stopped this cycle are masked so a grant never targets a vanishing flag.
    assign w_pick = rr_pick(o_pending & ~w_stop_vec, r_rr_ptr);

    // Arbiter next-state: grant from IDLE, release on ack or stop of the presented channel.
    always_comb begin
        w_arb_nxt    = r_arb_state;
        w_irq_id_nxt = r_irq_id;
        w_rr_nxt     = r_rr_ptr;
        case (r_arb_state)
            ARB_IDLE: begin
                if (w_pick[IDW]) begin
                    w_arb_nxt    = ARB_BUSY;
                    w_irq_id_nxt = w_pick[IDW-1:0];
                end
            end
            ARB_BUSY: begin
                if (w_ack_apply || w_stop_presented) begin
                    w_arb_nxt = ARB_IDLE;
                    w_rr_nxt  = (r_irq_id == IDW'(NCH - 1)) ? '0 : r_irq_id + 1'b1;
                end
            end
            default: w_arb_nxt = ARB_IDLE;
        endcase
    end

    // Arbiter registers; irq is the registered BUSY state so it rises a cycle after pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arb_state <= ARB_IDLE;
            r_irq_id    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_arb_state <= w_arb_nxt;
            r_irq_id    <= w_irq_id_nxt;
            r_rr_ptr    <= w_rr_nxt;
        end
    end

    assign o_irq    = (r_arb_state == ARB_BUSY);
    assign o_irq_id = r_irq_id;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed self-checking bench for irq_timer_ctrl (default build, NCH=4, CW=10).
module tb_irq_timer_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 10;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [IDW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_value;
    logic           cfg_periodic;
    logic           cfg_en;
    logic           irq;
    logic [IDW-1:0] irq_id;
    logic           irq_ack;
    logic [NCH-1:0] running;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_timer_ctrl #(.NCH(NCH), .CW(CW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cfg_we       (cfg_we),
        .i_cfg_ch       (cfg_ch),
        .i_cfg_value    (cfg_value),
        .i_cfg_periodic (cfg_periodic),
        .i_cfg_en       (cfg_en),
        .o_irq          (irq),
        .o_irq_id       (irq_id),
        .i_irq_ack      (irq_ack),
        .o_running      (running),
        .o_pending      (pending),
        .o_overrun      (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One config write; returns just after the sampling edge (E0).
    task automatic cfg(input int ch, input int val, input bit per, input bit en);
        cfg_we       = 1'b1;
        cfg_ch       = IDW'(ch);
        cfg_value    = CW'(val);
        cfg_periodic = per;
        cfg_en       = en;
        tick();
        cfg_we       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_value = '0;
        cfg_periodic = 1'b0; cfg_en = 1'b0; irq_ack = 1'b0;
        tick(); tick();
        chk("rst_irq",     32'(irq),     32'd0);
        chk("rst_irq_id",  32'(irq_id),  32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();

        // 1: ch0 one-shot V=5
        cfg(0, 5, 1'b0, 1'b1);
        chk("t1_run_e0", 32'(running), 32'h1);
        repeat (4) tick();
        chk("t1_pend_e4", 32'(pending), 32'h0);
        tick();
        chk("t1_pend_e5", 32'(pending), 32'h1);
        chk("t1_irq_e5",  32'(irq),     32'd0);
        chk("t1_run_e5",  32'(running), 32'h0);
        tick();
        chk("t1_irq_e6",  32'(irq),     32'd1);
        chk("t1_id_e6",   32'(irq_id),  32'd0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("t1_irq_ack",  32'(irq),     32'd0);
        chk("t1_pend_ack", 32'(pending), 32'h0);

        // 2: ch1 periodic V=3, prompt acks
        cfg(1, 3, 1'b1, 1'b1);
        repeat (3) tick();
        chk("t2_pend_e3", 32'(pending), 32'h2);
        tick();
        chk("t2_irq_e4", 32'(irq),    32'd1);
        chk("t2_id_e4",  32'(irq_id), 32'd1);
        for (int k = 0; k < 3; k++) begin
            irq_ack = 1'b1; tick(); irq_ack = 1'b0;
            chk("t2_irq_gap", 32'(irq), 32'd0);
            tick();
            chk("t2_pend_re", 32'(pending), 32'h2);
            chk("t2_irq_low", 32'(irq),     32'd0);
            tick();
            chk("t2_irq_rise", 32'(irq),    32'd1);
            chk("t2_id",       32'(irq_id), 32'd1);
        end
        chk("t2_ovr", 32'(overrun), 32'h0);
        cfg(1, 0, 1'b1, 1'b0);
        chk("t2_stop_irq",  32'(irq),     32'd0);
        chk("t2_stop_run",  32'(running), 32'h0);
        chk("t2_stop_pend", 32'(pending), 32'h0);

        // 3: ch2 periodic V=4, never acked
        cfg(2, 4, 1'b1, 1'b1);
        repeat (4) tick();
        chk("t3_pend_e4", 32'(pending), 32'h4);
        tick();
        chk("t3_irq_e5", 32'(irq),    32'd1);
        chk("t3_id_e5",  32'(irq_id), 32'd2);
        tick(); tick();
        chk("t3_ovr_e7", 32'(overrun), 32'h0);
        tick();
        chk("t3_ovr_e8",  32'(overrun), 32'h4);
        chk("t3_pend_e8", 32'(pending), 32'h4);
        chk("t3_irq_e8",  32'(irq),     32'd1);
        cfg(2, 0, 1'b0, 1'b0);
        chk("t3_stop_irq",  32'(irq),     32'd0);
        chk("t3_stop_pend", 32'(pending), 32'h0);
        chk("t3_stop_ovr",  32'(overrun), 32'h0);

        // 4: all four one-shot, staggered writes so they expire on the same edge
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) cfg(i, 7 - i, 1'b0, 1'b1);
        chk("t4_run", 32'(running), 32'hF);
        repeat (3) tick();
        chk("t4_pend_e6", 32'(pending), 32'h0);
        tick();
        chk("t4_pend_e7", 32'(pending), 32'hF);
        chk("t4_irq_e7",  32'(irq),     32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t4_irq",   32'(irq),    32'd1);
            chk("t4_order", 32'(irq_id), 32'(i));
            irq_ack = 1'b1; tick(); irq_ack = 1'b0;
            chk("t4_gap",    32'(irq),        32'd0);
            chk("t4_pclr",   32'(pending[i]), 32'd0);
            tick();
        end
        chk("t4_end_irq", 32'(irq),     32'd0);
        chk("t4_end_run", 32'(running), 32'h0);

        // 5: ch3 periodic V=2, ack lands on an expiry edge
        cfg(3, 2, 1'b1, 1'b1);
        tick(); tick();
        chk("t5_pend_e2", 32'(pending), 32'h8);
        tick();
        chk("t5_irq_e3", 32'(irq),    32'd1);
        chk("t5_id_e3",  32'(irq_id), 32'd3);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("t5_irq_e4",  32'(irq),     32'd0);
        chk("t5_pend_e4", 32'(pending), 32'h8);
        chk("t5_ovr_e4",  32'(overrun), 32'h0);
        tick();
        chk("t5_irq_e5", 32'(irq),    32'd1);
        chk("t5_id_e5",  32'(irq_id), 32'd3);

        // 6: reset with irq high, then a zero-value start is ignored
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_irq",  32'(irq),     32'd0);
        chk("t6_id",   32'(irq_id),  32'd0);
        chk("t6_run",  32'(running), 32'h0);
        chk("t6_pend", 32'(pending), 32'h0);
        chk("t6_ovr",  32'(overrun), 32'h0);
        cfg(0, 0, 1'b0, 1'b1);
        chk("t6_v0_run", 32'(running), 32'h0);
        repeat (3) tick();
        chk("t6_v0_irq",  32'(irq),     32'd0);
        chk("t6_v0_pend", 32'(pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
